vec_add_issue: RTL
==================

# vec_add_issue

Command-driven operand issue stage placed directly upstream of `ElemAdder` in the vector ALU. It accepts one vector-add command, streams two operand vectors out of two synchronous read ports, and presents aligned `op1`/`op2`/`p` beats with `valid`/`last` framing on the adder's input interface. It also flags operands that are out of range for the modulus, and reports command completion.

## Interface
Parameters:
- `ADDR_W`, default 12: operand buffer address width. Maximum vector length is 2^ADDR_W.
- Data width is `FSIZE`, taken from `FHE_ALU_PKG`. It is not a parameter of this block.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  block can accept a command. High only in IDLE.
- `cmd_src1_addr`, `cmd_src2_addr`  in  ADDR_W  base addresses of the two operand vectors.
- `cmd_len`  in  ADDR_W+1  element count, 0 to 2^ADDR_W.
- `cmd_p`  in  FSIZE  modulus.
- `hold`  in  1  suppresses new read issue this cycle.
- `rd1_en`, `rd2_en`  out  1  read strobes. The two strobes are always equal.
- `rd1_addr`, `rd2_addr`  out  ADDR_W  read addresses.
- `rd1_data`, `rd2_data`  in  FSIZE  read data, valid exactly 1 cycle after the strobe.
- `out_valid`, `out_last`  out  1  beat framing toward the adder's `in_valid`/`in_last`.
- `op1`, `op2`, `p`  out  FSIZE  operands and modulus.
- `done`  out  1  one-cycle completion pulse.
- `range_err`  out  1  sticky: some issued operand was ≥ p.

## Operation
- The FSM has three states: IDLE, RUN, DRAIN. Reset enters IDLE.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid` the block latches the bases, `cmd_len` and `cmd_p`, clears `idx` and clears `range_err`.
  - If `cmd_len`≠0 it goes to RUN.
  - If `cmd_len`=0 it stays in IDLE, issues no reads, and pulses `done` the following cycle.
- RUN:
  - In each cycle with `hold`=0: `rd*_en`=1, `rd1_addr`=src1+idx and `rd2_addr`=src2+idx, both truncated mod 2^ADDR_W (wrap-around is legal). Then `idx`++.
  - Issuing `idx`=len−1 moves the FSM to DRAIN.
  - While `hold`=1, `rd*_en`=0 and `idx` is frozen.
- DRAIN:
  - No reads are issued. Wait for the final beat to leave the output register, then return to IDLE.
  - DRAIN lasts exactly 2 cycles.
- Return path (independent of state):
  - The strobe is delayed one cycle with a tag that marks the last element.
  - The return data is registered into `op1`/`op2` together with `out_valid`/`out_last`.
  - `out_valid` is the issue strobe delayed by 2 cycles. Held cycles therefore appear as gaps: `out_valid`=0, and `op1`/`op2` keep their previous values.
- `p` holds the latched `cmd_p` from command accept until the next accept. It is stable across the whole vector.
- Range check:
  - Compare `rd1_data` ≥ p and `rd2_data` ≥ p on returning beats.
  - `range_err` sets in the cycle the offending beat is output and stays set until the next command is accepted.
  - Data is passed through unmodified.
- `done` is high in the same cycle as the beat with `out_last`=1. For `cmd_len`=0 it is high the cycle after accept.

## Timing
- Reset values: `cmd_ready`=1; every other output is 0, including `op1`, `op2`, `p`, `done` and `range_err`. The internal `idx` and delay pipeline are also cleared.
- Assertion of `rstn` mid-command aborts the command immediately. Beats that are in flight are discarded, so no `out_valid` or `done` occurs after reset.
- Latency: a read issued in cycle t produces its beat in cycle t+2.
- With `hold` never asserted, a length-N vector has these cycles:
  - accept = cycle 0
  - reads in cycles 1 to N
  - beats in cycles 3 to N+2
  - `done` in cycle N+2
  - `cmd_ready` back to 1 in cycle N+3
- `out_last` is asserted exactly once per nonzero command, on beat N.
- A `hold` arriving in the same cycle the FSM enters RUN is honoured: the first read is delayed.
- A `cmd_valid` held high continuously is accepted again in the first IDLE cycle. There is no back-to-back overlap between commands.

## Test plan
- src1=0x010, src2=0x200, len=4, p=97, buffers hold [1,2,3,4] and [5,6,7,8]:
  - reads in cycles 1–4 at addresses 0x010–0x013 and 0x200–0x203
  - beats in cycles 3–6 with op1=1..4, op2=5..8, p=97
  - `out_last` and `done` in cycle 6; `range_err`=0
- Same command with `hold`=1 in cycles 2–3: reads in cycles 1, 4, 5, 6; beats in cycles 3, 6, 7, 8 with `out_valid` low in cycles 4–5; `done` in cycle 8.
- Length and wrap cases:
  - len=1 gives a single beat with `out_valid`=`out_last`=`done`=1 in cycle 3.
  - len=0 gives no reads, no beats, and `done` in cycle 1.
- ADDR_W=12, src1=0xFFE, len=4: `rd1_addr` sequence is 0xFFE, 0xFFF, 0x000, 0x001.
- Range error:
  - p=97 and the third op2 is 97: `range_err` rises with beat 3 and stays high after `done`.
  - The next command's accept clears `range_err`.
- `rstn` pulsed low for one cycle while in RUN with len=8:
  - all outputs go to their reset values immediately and no further beats appear
  - `cmd_ready`=1 after reset releases
  - a new command runs normally

Source files
------------

// File: rtl/vec_add_issue.sv
// vec_add_issue -- operand issue stage feeding ElemAdder.
//
// Accepts one vector-add command. It streams two operand vectors out of two
// synchronous read ports and presents aligned op1/op2/p beats with
// out_valid/out_last framing. It also flags operands that are >= p and
// pulses done when the command completes.
//
// Ports:
//   clk, rstn                       clock, async active-low reset
//   cmd_valid / cmd_ready           command handshake (ready only in IDLE)
//   cmd_src1_addr, cmd_src2_addr    operand vector base addresses
//   cmd_len                         element count, 0 .. 2^ADDR_W
//   cmd_p                           modulus
//   hold                            suppress read issue this cycle
//   rd1_en/rd1_addr/rd1_data        operand 1 read port (data 1 cycle after en)
//   rd2_en/rd2_addr/rd2_data        operand 2 read port (data 1 cycle after en)
//   out_valid, out_last             beat framing toward the adder
//   op1, op2, p                     beat operands and modulus
//   done                            one-cycle completion pulse
//   range_err                       sticky: an issued operand was >= p

package FHE_ALU_PKG;
  localparam int FSIZE = 64;
endpackage

module vec_add_issue
  import FHE_ALU_PKG::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_src1_addr,
  input  logic [ADDR_W-1:0] cmd_src2_addr,
  input  logic [ADDR_W:0]   cmd_len,
  input  logic [FSIZE-1:0]  cmd_p,
  input  logic              hold,
  output logic              rd1_en,
  output logic              rd2_en,
  output logic [ADDR_W-1:0] rd1_addr,
  output logic [ADDR_W-1:0] rd2_addr,
  input  logic [FSIZE-1:0]  rd1_data,
  input  logic [FSIZE-1:0]  rd2_data,
  output logic              out_valid,
  output logic              out_last,
  output logic [FSIZE-1:0]  op1,
  output logic [FSIZE-1:0]  op2,
  output logic [FSIZE-1:0]  p,
  output logic              done,
  output logic              range_err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_src1;
  logic [ADDR_W-1:0] r_src2;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_idx;
  logic [FSIZE-1:0]  r_p;

  logic              r_ret_v;
  logic              r_ret_last;
  logic              r_out_valid;
  logic              r_out_last;
  logic [FSIZE-1:0]  r_op1;
  logic [FSIZE-1:0]  r_op2;
  logic              r_done;
  logic              r_range_err;

  logic              w_accept;
  logic              w_issue;
  logic              w_issue_last;
  logic [ADDR_W:0]   w_len_m1;
  logic [ADDR_W-1:0] w_addr1;
  logic [ADDR_W-1:0] w_addr2;

  assign w_accept     = (r_state == S_IDLE) && cmd_valid;
  assign w_issue      = (r_state == S_RUN) && !hold;
  assign w_len_m1     = r_len - (ADDR_W+1)'(1);
  assign w_issue_last = w_issue && (r_idx == w_len_m1);
  // Address arithmetic wraps modulo 2^ADDR_W by truncation.
  assign w_addr1      = r_src1 + r_idx[ADDR_W-1:0];
  assign w_addr2      = r_src2 + r_idx[ADDR_W-1:0];

  assign cmd_ready = (r_state == S_IDLE);
  assign rd1_en    = w_issue;
  assign rd2_en    = w_issue;
  assign rd1_addr  = w_issue ? w_addr1 : '0;
  assign rd2_addr  = w_issue ? w_addr2 : '0;

  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign op1       = r_op1;
  assign op2       = r_op2;
  assign p         = r_p;
  assign done      = r_done;
  assign range_err = r_range_err;

  // Command FSM and issue counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_src1  <= '0;
      r_src2  <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_p     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_src1 <= cmd_src1_addr;
            r_src2 <= cmd_src2_addr;
            r_len  <= cmd_len;
            r_p    <= cmd_p;
            r_idx  <= '0;
            if (cmd_len != '0) r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_issue) begin
            r_idx <= r_idx + (ADDR_W+1)'(1);
            if (w_issue_last) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // The last beat sits in the output register this cycle.
          if (r_out_valid && r_out_last) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Return path: strobe+tag delayed one cycle, then beat registered with data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ret_v     <= 1'b0;
      r_ret_last  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_done      <= 1'b0;
      r_range_err <= 1'b0;
    end else begin
      r_ret_v     <= w_issue;
      r_ret_last  <= w_issue_last;
      r_out_valid <= r_ret_v;
      r_out_last  <= r_ret_v && r_ret_last;
      if (r_ret_v) begin
        r_op1 <= rd1_data;
        r_op2 <= rd2_data;
      end
      // Zero-length commands complete in the cycle after accept.
      r_done <= (r_ret_v && r_ret_last) || (w_accept && (cmd_len == '0));
      if (w_accept)
        r_range_err <= 1'b0;
      else if (r_ret_v && ((rd1_data >= r_p) || (rd2_data >= r_p)))
        r_range_err <= 1'b1;
    end
  end

endmodule
